// File: rtl/demux_18_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_18_reg_pkg
// Description : Shared constants and the one-hot helper for the 1-to-8
//               registered distributor.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_18_reg_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int NUM_CH_DEF = 8;
  localparam int SEL_W_DEF  = 3;

  localparam logic [NUM_CH_DEF-1:0] FULL_MASK = {NUM_CH_DEF{1'b1}};

  function automatic logic [NUM_CH_DEF-1:0] onehot(input logic [SEL_W_DEF-1:0] sel);
    logic [NUM_CH_DEF-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_ch_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_ch_reg
// Description : One channel holding register with load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_ch_reg
  import demux_18_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/demux_18_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_18_reg
// Description : Registered 1-to-8 distributor with auto pointer, written mask
//               and frame-completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_18_reg
  import demux_18_reg_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        in_num,
  input  logic                    auto_mode,
  input  logic                    clr,
  output logic [NUM_CH*WIDTH-1:0] out_bus,
  output logic [NUM_CH-1:0]       wr_strobe,
  output logic [SEL_W-1:0]        ptr,
  output logic [NUM_CH-1:0]       written,
  output logic                    frame_done
);

  logic [SEL_W-1:0]  r_ptr;
  logic [NUM_CH-1:0] r_written;
  logic [NUM_CH-1:0] r_strobe;
  logic              r_frame_done;

  logic [SEL_W-1:0]  w_tgt;
  logic [NUM_CH-1:0] w_tgt_oh;
  logic [NUM_CH-1:0] w_mask_next;
  logic              w_accept;

  assign w_tgt       = auto_mode ? r_ptr : in_num;
  assign w_tgt_oh    = onehot(w_tgt);
  assign w_mask_next = r_written | w_tgt_oh;
  // clr wins over a write presented in the same cycle
  assign w_accept    = in_valid & ~clr;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      demux_ch_reg #(
        .WIDTH (WIDTH)
      ) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept & w_tgt_oh[k]),
        .d     (in_data),
        .q     (out_bus[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_written    <= '0;
      r_strobe     <= '0;
      r_frame_done <= 1'b0;
    end else if (clr) begin
      r_ptr        <= '0;
      r_written    <= '0;
      r_strobe     <= '0;
      r_frame_done <= 1'b0;
    end else if (in_valid) begin
      r_strobe <= w_tgt_oh;
      if (auto_mode) begin
        r_ptr <= r_ptr + 1'b1;
      end
      // Completing bit is folded straight into the clear, never seen set
      if (w_mask_next == FULL_MASK) begin
        r_written    <= '0;
        r_frame_done <= 1'b1;
      end else begin
        r_written    <= w_mask_next;
        r_frame_done <= 1'b0;
      end
    end else begin
      r_strobe     <= '0;
      r_frame_done <= 1'b0;
    end
  end

  assign wr_strobe  = r_strobe;
  assign ptr        = r_ptr;
  assign written    = r_written;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_demux_18_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_18_reg
// Description : Table-driven self-checking bench for demux_18_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_18_reg;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_data;
  logic        in_valid;
  logic [2:0]  in_num;
  logic        auto_mode;
  logic        clr;
  logic [31:0] out_bus;
  logic [7:0]  wr_strobe;
  logic [2:0]  ptr;
  logic [7:0]  written;
  logic        frame_done;

  int n_pass;
  int n_total;

  demux_18_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_num     (in_num),
    .auto_mode  (auto_mode),
    .clr        (clr),
    .out_bus    (out_bus),
    .wr_strobe  (wr_strobe),
    .ptr        (ptr),
    .written    (written),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       a;
    logic       c;
    logic [2:0] n;
    logic [3:0] d;
    logic [7:0] es;
    logic [2:0] ep;
    logic [7:0] ew;
    logic       ef;
    logic [2:0] ech;
    logic [3:0] eval;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic add(input logic v, input logic a, input logic c, input logic [2:0] n,
                     input logic [3:0] d, input logic [7:0] es, input logic [2:0] ep,
                     input logic [7:0] ew, input logic ef, input logic [2:0] ech,
                     input logic [3:0] eval);
    vec_t r;
    r.v = v; r.a = a; r.c = c; r.n = n; r.d = d;
    r.es = es; r.ep = ep; r.ew = ew; r.ef = ef; r.ech = ech; r.eval = eval;
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ebus;
    logic [7:0]  m;
    n_pass  = 0;
    n_total = 0;
    ebus    = '0;

    // Manual write to channel 5
    add(1, 0, 0, 3'd5, 4'hA, 8'h20, 3'd0, 8'h20, 0, 3'd5, 4'hA);
    // clr: mask cleared, data kept
    add(0, 0, 1, 3'd0, 4'h0, 8'h00, 3'd0, 8'h00, 0, 3'd5, 4'hA);
    // Auto frame writing 1..8
    for (int k = 0; k < 8; k++) begin
      m = (k < 7) ? 8'((1 << (k + 1)) - 1) : 8'h00;
      add(1, 1, 0, 3'd0, 4'(k + 1), 8'(1 << k), 3'((k + 1) % 8), m, (k == 7), 3'(k), 4'(k + 1));
    end
    add(0, 1, 0, 3'd0, 4'h0, 8'h00, 3'd0, 8'h00, 0, 3'd0, 4'h1);
    // Manual partial frame 0..6, overwrite 3, then complete with 7
    for (int k = 0; k < 7; k++) begin
      add(1, 0, 0, 3'(k), 4'(8 + k), 8'(1 << k), 3'd0, 8'((1 << (k + 1)) - 1), 0, 3'(k), 4'(8 + k));
    end
    add(1, 0, 0, 3'd3, 4'hF, 8'h08, 3'd0, 8'h7F, 0, 3'd3, 4'hF);
    add(1, 0, 0, 3'd7, 4'hC, 8'h80, 3'd0, 8'h00, 1, 3'd7, 4'hC);
    // Reach ptr=3, written=07, then clr with a competing write
    add(1, 1, 0, 3'd0, 4'h1, 8'h01, 3'd1, 8'h01, 0, 3'd0, 4'h1);
    add(1, 1, 0, 3'd0, 4'h2, 8'h02, 3'd2, 8'h03, 0, 3'd1, 4'h2);
    add(1, 1, 0, 3'd0, 4'h3, 8'h04, 3'd3, 8'h07, 0, 3'd2, 4'h3);
    add(1, 1, 1, 3'd0, 4'h9, 8'h00, 3'd0, 8'h00, 0, 3'd3, 4'hF);
    // Mode toggling leaves the pointer alone
    add(1, 1, 0, 3'd0, 4'h1, 8'h01, 3'd1, 8'h01, 0, 3'd0, 4'h1);
    add(1, 0, 0, 3'd6, 4'h5, 8'h40, 3'd1, 8'h41, 0, 3'd6, 4'h5);
    add(1, 1, 0, 3'd0, 4'h7, 8'h02, 3'd2, 8'h43, 0, 3'd1, 4'h7);

    // Reset held with a write request pending
    rst_n = 1'b0; in_valid = 1'b1; in_data = 4'hF; in_num = 3'd2;
    auto_mode = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_bus", out_bus, 32'h0);
    chk("rst_ptr", {29'h0, ptr}, 32'h0);
    chk("rst_written", {24'h0, written}, 32'h0);
    chk("rst_strobe", {24'h0, wr_strobe}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    rst_n = 1'b1; in_valid = 1'b0;

    foreach (tbl[i]) begin
      in_valid  = tbl[i].v;
      auto_mode = tbl[i].a;
      clr       = tbl[i].c;
      in_num    = tbl[i].n;
      in_data   = tbl[i].d;
      @(posedge clk);
      #1;
      if (tbl[i].v && !tbl[i].c) ebus[tbl[i].ech*4 +: 4] = tbl[i].eval;
      chk($sformatf("v%0d_strobe", i), {24'h0, wr_strobe}, {24'h0, tbl[i].es});
      chk($sformatf("v%0d_ptr", i), {29'h0, ptr}, {29'h0, tbl[i].ep});
      chk($sformatf("v%0d_written", i), {24'h0, written}, {24'h0, tbl[i].ew});
      chk($sformatf("v%0d_frame_done", i), {31'h0, frame_done}, {31'h0, tbl[i].ef});
      chk($sformatf("v%0d_ch", i), {28'h0, out_bus[tbl[i].ech*4 +: 4]}, {28'h0, tbl[i].eval});
      chk($sformatf("v%0d_bus", i), out_bus, ebus);
    end

    // Asynchronous reset between edges, mid-frame
    in_valid = 1'b1; auto_mode = 1'b1; clr = 1'b0; in_data = 4'h6;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_bus", out_bus, 32'h0);
    chk("arst_ptr", {29'h0, ptr}, 32'h0);
    chk("arst_written", {24'h0, written}, 32'h0);
    chk("arst_strobe", {24'h0, wr_strobe}, 32'h0);
    chk("arst_frame_done", {31'h0, frame_done}, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_bus", out_bus, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_first_write", out_bus, 32'h0000_0006);
    chk("arst_first_ptr", {29'h0, ptr}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
